// File: rtl/game_pkg.sv
// Shared game constants and state encoding, common to the compositor, pipe
// and bird stages and the game-level sequencer.
package game_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_PLAY = 2'b01,
        ST_DEAD = 2'b10
    } state_e;

    localparam int unsigned BIRD_X   = 200;
    localparam int unsigned SPRITE_H = 32;
    localparam int unsigned FLOOR_Y  = 448;
    localparam int unsigned FRAME_V  = 480;

    localparam int unsigned H_ACTIVE = 640;
    localparam int unsigned V_ACTIVE = 480;

endpackage

// File: rtl/bcd_counter4.sv
// Four-digit BCD counter with synchronous clear and increment enable.
// Saturates at 9999 instead of wrapping.
module bcd_counter4 (
    input  logic        clk,
    input  logic        reset,
    input  logic        clr,
    input  logic        inc,
    output logic [15:0] value
);

    logic [15:0] count_q, count_d;
    logic        carry;

    always_comb begin
        count_d = count_q;
        carry   = inc && (count_q != 16'h9999);
        // Digit 0 takes the increment; a 9 rolls to 0 and passes the carry up.
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (count_q[4*i +: 4] == 4'd9) begin
                    count_d[4*i +: 4] = 4'd0;
                end else begin
                    count_d[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
                    carry             = 1'b0;
                end
            end
        end
        if (clr) begin
            count_d = 16'h0000;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            count_q <= 16'h0000;
        end else begin
            count_q <= count_d;
        end
    end

    assign value = count_q;

endmodule

// File: rtl/game_state_ctrl.sv
// Game-level sequencer: collision latch, pass scoring and the IDLE/PLAY/DEAD
// flow that drives run_enable, the BCD score and the restart pulse.
module game_state_ctrl
    import game_pkg::*;
#(
    parameter int unsigned DEAD_HOLD = 60
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        bright,
    input  logic [9:0]  hCount,
    input  logic [9:0]  vCount,
    input  logic        show_sprite,
    input  logic        sprite_opaque,
    input  logic        pipe_pixel,
    input  logic [9:0]  bird_y,
    input  logic [9:0]  pipe_right_x,
    input  logic        button,
    output logic        run_enable,
    output logic [1:0]  game_state,
    output logic [15:0] score,
    output logic        restart
);

    localparam int unsigned CntW = $clog2(DEAD_HOLD + 1);

    state_e          state_q, state_d;
    logic            btn_s1_q, btn_s2_q, btn_s3_q;
    logic            hit_q;
    logic [9:0]      prev_x_q;
    logic [CntW-1:0] hold_cnt_q;
    logic            run_enable_q, run_enable_d;
    logic [1:0]      game_state_q, game_state_d;
    logic            restart_q;

    logic btn_rise, ftick, hit_set, floor_death, pass, die, hold_done;
    logic go_idle, score_inc, score_clr;

    assign btn_rise    = btn_s2_q & ~btn_s3_q;
    assign ftick       = (hCount == 10'd0) && (vCount == 10'(FRAME_V));
    assign hit_set     = bright & show_sprite & sprite_opaque & pipe_pixel;
    // 11-bit sum so a bird near the bottom of the range cannot wrap past the floor.
    assign floor_death = (({1'b0, bird_y} + 11'(SPRITE_H)) >= 11'(FLOOR_Y)) ||
                         (bird_y == 10'd0);
    assign pass        = (prev_x_q >= 10'(BIRD_X)) && (pipe_right_x < 10'(BIRD_X));
    assign die         = hit_q | floor_death;
    assign hold_done   = (hold_cnt_q == CntW'(DEAD_HOLD));

    always_ff @(posedge clk) begin
        if (!reset) begin
            btn_s1_q   <= 1'b0;
            btn_s2_q   <= 1'b0;
            btn_s3_q   <= 1'b0;
            hit_q      <= 1'b0;
            prev_x_q   <= 10'd0;
            hold_cnt_q <= '0;
        end else begin
            btn_s1_q <= button;
            btn_s2_q <= btn_s1_q;
            btn_s3_q <= btn_s2_q;
            // A hit landing on the tick itself survives into the next frame.
            if (hit_set) begin
                hit_q <= 1'b1;
            end else if (ftick) begin
                hit_q <= 1'b0;
            end
            if (ftick) begin
                prev_x_q <= pipe_right_x;
            end
            if (state_q != ST_DEAD) begin
                hold_cnt_q <= '0;
            end else if (ftick && !hold_done) begin
                hold_cnt_q <= hold_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            run_enable_q <= 1'b0;
            game_state_q <= 2'b00;
            restart_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            run_enable_q <= run_enable_d;
            game_state_q <= game_state_d;
            restart_q    <= go_idle;
        end
    end

    always_comb begin
        state_d   = state_q;
        go_idle   = 1'b0;
        score_inc = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (btn_rise) state_d = ST_PLAY;
            end
            ST_PLAY: begin
                if (ftick) begin
                    if (die) begin
                        state_d = ST_DEAD;
                    end else begin
                        score_inc = pass;
                    end
                end
            end
            ST_DEAD: begin
                if (btn_rise && hold_done) begin
                    state_d = ST_IDLE;
                    go_idle = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        score_clr = (state_q == ST_IDLE) || go_idle;
    end

    always_comb begin
        run_enable_d = (state_q == ST_PLAY);
        game_state_d = state_q;
    end

    bcd_counter4 u_score (
        .clk   (clk),
        .reset (reset),
        .clr   (score_clr),
        .inc   (score_inc),
        .value (score)
    );

    assign run_enable = run_enable_q;
    assign game_state = game_state_q;
    assign restart    = restart_q;

endmodule

// File: doc/game_state_ctrl.md
Name: game_state_ctrl

Overview:
- Game-level sequencer that sits downstream of the pixel-compositing stage and upstream of the pipe and bird motion stages.
- Watches per-pixel bird/pipe overlap during active video to detect collisions.
- Counts pipes cleared and runs the IDLE/PLAY/DEAD game flow.
- Drives the run enable that gates pipe scrolling, and the 4-digit BCD score shown on the seven-segment display.

Parameters:
- BIRD_X, 200, left column of bird sprite (pixels)
- SPRITE_H, 32, bird sprite height (pixels)
- FLOOR_Y, 448, bird_y + SPRITE_H at or above this value is a floor death
- FRAME_V, 480, vCount line at which the frame tick fires (start of vblank)
- DEAD_HOLD, 60, frames DEAD must last before a restart press is accepted

Ports:
- clk  in  1  system pixel clock
- reset  in  1  synchronous, active-low reset
- bright  in  1  active-video qualifier
- hCount  in  10  current pixel column
- vCount  in  10  current pixel row
- show_sprite  in  1  current pixel lies inside the bird sprite box
- sprite_opaque  in  1  bird sprite pixel is not transparent
- pipe_pixel  in  1  current pixel is pipe
- bird_y  in  10  bird sprite top row
- pipe_right_x  in  10  right edge of the leading pipe pair, screen columns
- button  in  1  raw flap/start button, asynchronous
- run_enable  out  1  high only in PLAY; gates pipe scroll and physics
- game_state  out  2  00 IDLE, 01 PLAY, 10 DEAD
- score  out  16  4-digit BCD, digit 3 in [15:12]
- restart  out  1  one-cycle pulse on DEAD->IDLE; resets downstream positions

Behaviour:
- Reset (reset==0 at a clk edge):
  - state=IDLE, score=0, run_enable=0, restart=0.
  - Hit latch, frame counter, pipe-position register and button synchroniser all cleared.
- Button input:
  - 2-flop synchroniser, then a rising-edge detector giving btn_rise, a single-cycle pulse.
  - Latency from raw edge to btn_rise is 3 clk.
- Frame tick:
  - ftick=1 for exactly one clk when hCount==0 && vCount==FRAME_V.
  - All game decisions except IDLE->PLAY are evaluated on ftick only.
- Hit latch:
  - Set on any clk where bright && show_sprite && sprite_opaque && pipe_pixel.
  - Cleared on the clk after ftick.
  - Set and clear in the same cycle: set wins, so the hit carries into the next frame.
- Floor/ceiling death: bird_y + SPRITE_H >= FLOOR_Y, or bird_y == 0. Evaluated at ftick with 11-bit arithmetic so there is no wrap.
- Scoring:
  - pipe_right_x is registered as prev_x at each ftick.
  - A pass is detected when prev_x >= BIRD_X && pipe_right_x < BIRD_X.
  - A pipe respawn (pipe_right_x jumping from low to high) never scores.
- FSM:
  - IDLE: run_enable=0, score held at 0. btn_rise -> PLAY on the next clk. btn_rise does not need to wait for ftick.
  - PLAY: run_enable=1. At ftick:
    - If hit latch or floor/ceiling death -> DEAD, and the score does not increment that frame. Death takes priority over a simultaneous pass.
    - Else if a pass is detected, increment score.
  - DEAD: run_enable=0, score frozen.
    - Frame counter increments on ftick and saturates at DEAD_HOLD.
    - btn_rise while counter==DEAD_HOLD -> IDLE, with restart=1 for that single clk and score cleared to 0.
    - btn_rise before the hold expires is ignored.
- BCD increment:
  - Ripple carry across the digits: 0009->0010, 0099->0100.
  - Saturates at 9999; no wrap.
- run_enable and game_state are registered: 1 clk after the state transition.
- Reset asserted mid-game: returns to IDLE on the next edge regardless of state; restart is not pulsed.

Decomposition:
- Shared package game_pkg holds:
  - state encodings ST_IDLE/ST_PLAY/ST_DEAD
  - BIRD_X, SPRITE_H, FLOOR_Y, FRAME_V
  - screen-width constants shared with the compositor and the pipe stage
- One natural sub-module: bcd_counter4 (sync clear, increment enable, saturating at 9999, 16-bit BCD out).

Test Plan:
- Reset then idle: hold reset low 2 clk, run 3 frames with no button -> state=00, run_enable=0, score=0x0000.
- Start: pulse button -> state=01 within 4 clk. Then sweep pipe_right_x 230->190 across one ftick with no overlap -> score=0x0001. Then a respawn 190->600 -> score remains 0x0001.
- Collision:
  - In PLAY, assert show_sprite&sprite_opaque&pipe_pixel&bright for 1 pixel mid-frame -> state=10 one clk after next ftick, run_enable=0.
  - Same overlap with sprite_opaque=0 -> stays PLAY.
- Simultaneous pass and hit in the same frame -> state=10, score unchanged.
- Floor: bird_y=416 at ftick -> DEAD. Then press at frame 30 -> ignored. Press at frame 61 -> restart pulses exactly 1 clk, state=00, score=0x0000.
- BCD:
  - Preload via 99 passes -> 0x0099, next pass -> 0x0100.
  - From 0x9999, pass -> stays 0x9999.
